seven_seg_reader: RTL and testbench

//   Reads back a multiplexed, active-low 7-segment display bus and recovers the hex digit on each position.

---
 rtl/seven_seg_reader.sv | 246 ++++++++++++++++++++++++
 tb/tb_seven_seg_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_reader.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus with debounce and valid/ready output.
// Define SEVSEG_FRAME_EN to build the full-frame assembler (frame/frame_valid); otherwise they are tied to 0.
module seven_seg_reader #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8,
    localparam int unsigned IdxW         = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_digit,
    output logic [IdxW-1:0]         out_index,
    output logic                    out_err,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] frame,
    output logic                    frame_valid
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StHold   = 2'd2;

    // Returns {err, digit}
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h01:   r = {1'b0, 4'h0};
            7'h4F:   r = {1'b0, 4'h1};
            7'h12:   r = {1'b0, 4'h2};
            7'h06:   r = {1'b0, 4'h3};
            7'h4C:   r = {1'b0, 4'h4};
            7'h24:   r = {1'b0, 4'h5};
            7'h20:   r = {1'b0, 4'h6};
            7'h0F:   r = {1'b0, 4'h7};
            7'h00:   r = {1'b0, 4'h8};
            7'h04:   r = {1'b0, 4'h9};
            7'h08:   r = {1'b0, 4'hA};
            7'h60:   r = {1'b0, 4'hB};
            7'h31:   r = {1'b0, 4'hC};
            7'h42:   r = {1'b0, 4'hD};
            7'h30:   r = {1'b0, 4'hE};
            7'h38:   r = {1'b0, 4'hF};
            default: r = {1'b1, 4'h0};
        endcase
        return r;
    endfunction

    logic [6:0]            seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0] dig_s1_q, dig_s2_q;
    logic [6:0]            lat_seg_q, lat_seg_d;
    logic [NUM_DIGITS-1:0] lat_dig_q, lat_dig_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [1:0]            state_q, state_d;
    logic                  valid_q, valid_d;
    logic [3:0]            digit_q, digit_d;
    logic [IdxW-1:0]       index_q, index_d;
    logic                  err_q, err_d;
    logic                  ovf_q, ovf_d;

    logic [NUM_DIGITS-1:0] dig_on;
    logic                  active;
    logic                  same;
    logic                  capture;
    logic                  load;
    logic [4:0]            cap_dec;
    logic [IdxW-1:0]       cap_idx;

    assign dig_on = ~dig_s2_q;
    assign active = (dig_on != '0) && ((dig_on & (dig_on - NUM_DIGITS'(1))) == '0)
                    && (seg_s2_q != 7'h7F);
    assign same   = (seg_s2_q == lat_seg_q) && (dig_s2_q == lat_dig_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_seg_d = lat_seg_q;
        lat_dig_d = lat_dig_q;
        capture   = 1'b0;
        case (state_q)
            StIdle: begin
                if (active) begin
                    lat_seg_d = seg_s2_q;
                    lat_dig_d = dig_s2_q;
                    cnt_d     = CntOne;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                if (!active) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (same) begin
                    if (cnt_q < CntMax) begin
                        cnt_d = cnt_q + CntOne;
                    end
                    if (cnt_q + CntOne == CntMax) begin
                        capture = 1'b1;
                        state_d = StHold;
                    end
                end else begin
                    lat_seg_d = seg_s2_q;
                    lat_dig_d = dig_s2_q;
                    cnt_d     = CntOne;
                end
            end
            StHold: begin
                if (!active) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (!same) begin
                    lat_seg_d = seg_s2_q;
                    lat_dig_d = dig_s2_q;
                    cnt_d     = CntOne;
                    state_d   = StSettle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // A capture only fires while the live sample equals the latched pair.
    assign cap_dec = decode(lat_seg_q);

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!lat_dig_q[i]) begin
                cap_idx = IdxW'(i);
            end
        end
    end

    assign load = capture && (!valid_q || out_ready);

    always_comb begin
        valid_d = valid_q;
        digit_d = digit_q;
        index_d = index_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            digit_d = cap_dec[3:0];
            index_d = cap_idx;
            err_d   = cap_dec[4];
        end else if (capture) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s1_q  <= 7'h7F;
            seg_s2_q  <= 7'h7F;
            dig_s1_q  <= '1;
            dig_s2_q  <= '1;
            lat_seg_q <= 7'h7F;
            lat_dig_q <= '1;
            cnt_q     <= '0;
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            digit_q   <= '0;
            index_q   <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            seg_s1_q  <= seg_n;
            seg_s2_q  <= seg_s1_q;
            dig_s1_q  <= dig_sel_n;
            dig_s2_q  <= dig_s1_q;
            lat_seg_q <= lat_seg_d;
            lat_dig_q <= lat_dig_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            digit_q   <= digit_d;
            index_q   <= index_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_digit = digit_q;
    assign out_index = index_q;
    assign out_err   = err_q;
    assign overflow  = ovf_q;

`ifdef SEVSEG_FRAME_EN
    logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_n;
    logic                    fv_q, fv_d;

    always_comb begin
        frame_d = frame_q;
        seen_d  = seen_q;
        seen_n  = seen_q | (NUM_DIGITS'(1) << cap_idx);
        fv_d    = 1'b0;
        if (load) begin
            if (cap_dec[4]) begin
                seen_d = '0;
            end else begin
                frame_d[4*cap_idx +: 4] = cap_dec[3:0];
                if (&seen_n) begin
                    fv_d   = 1'b1;
                    seen_d = '0;
                end else begin
                    seen_d = seen_n;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q <= '0;
            seen_q  <= '0;
            fv_q    <= 1'b0;
        end else begin
            frame_q <= frame_d;
            seen_q  <= seen_d;
            fv_q    <= fv_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = fv_q;
`else
    assign frame       = '0;
    assign frame_valid = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader: a run-length pin model predicts captures, a forked
// monitor pops and compares every accepted output transfer.
module tb_seven_seg_reader;

    localparam int ND = 4;
    localparam int S  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [6:0]      seg_n = 7'h7F;
    logic [ND-1:0]   dig_sel_n = '1;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_digit;
    logic [IW-1:0]   out_index;
    logic            out_err;
    logic            overflow;
    logic [4*ND-1:0] frame;
    logic            frame_valid;

    logic rdy_mode  = 1'b0;
    logic rdy_fixed = 1'b1;
    logic rnd_rdy   = 1'b1;
    assign out_ready = rdy_mode ? rnd_rdy : rdy_fixed;

    seven_seg_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_n      (seg_n),
        .dig_sel_n  (dig_sel_n),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digit  (out_digit),
        .out_index  (out_index),
        .out_err    (out_err),
        .overflow   (overflow),
        .frame      (frame),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [6:0] exp_q[$];
    logic [6:0] tbl[16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    logic [ND-1:0]   m_dig = '1;
    logic [6:0]      m_seg = 7'h7F;
    int              run_len = 0;
    int              stall = 0;
    int              fv_cnt = 0;
    int              nz_frame = 0;
    logic [4*ND-1:0] fv_frame = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {err, digit, index} straight from the decode table.
    function automatic logic [6:0] ref_capture(input logic [ND-1:0] dig, input logic [6:0] seg);
        logic [3:0]    d = 4'h0;
        logic          e = 1'b1;
        logic [IW-1:0] idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == tbl[i]) begin
                d = 4'(i);
                e = 1'b0;
            end
        end
        for (int i = 0; i < ND; i++) begin
            if (!dig[i]) idx = IW'(i);
        end
        return {e, d, idx};
    endfunction

    function automatic bit is_active(input logic [ND-1:0] dig, input logic [6:0] seg);
        return ($countones(~dig) == 1) && (seg != 7'h7F);
    endfunction

    // One capture per unbroken run of an identical active pair lasting S or more samples.
    task automatic apply(input logic [ND-1:0] dig, input logic [6:0] seg, input int hold,
                         input bit keep);
        if (dig == m_dig && seg == m_seg) run_len += hold;
        else run_len = hold;
        if (keep && is_active(dig, seg) && run_len >= S && run_len - hold < S)
            exp_q.push_back(ref_capture(dig, seg));
        m_dig     = dig;
        m_seg     = seg;
        dig_sel_n = dig;
        seg_n     = seg;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_hold(input logic [ND-1:0] dig, input logic [6:0] seg, input int hold,
                              input bit keep);
        apply(dig, seg, hold, keep);
        cyc(hold);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(4'b1111, 7'h7F, 0, 1'b0);
        run_len = 0;
        exp_q.delete();
        cyc(3);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_digit", 32'(out_digit), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame", 32'(frame), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_capture: got %0h expected none at %0t",
                             {out_err, out_digit, out_index}, $time);
                end else begin
                    check("capture", 32'({out_err, out_digit, out_index}), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    // Random backpressure, but never long enough to force a dropped capture.
    task automatic ready_loop();
        forever begin
            @(negedge clk);
            if (out_valid && !out_ready) stall++;
            else stall = 0;
            @(posedge clk);
            #1;
            rnd_rdy = (stall >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic frame_loop();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_valid) begin
                    fv_cnt++;
                    fv_frame = frame;
                end
                if (frame != '0) nz_frame++;
            end
        end
    endtask

    initial begin
        logic [ND-1:0] rd;
        logic [6:0]    rs;
        int            r;
        fork
            monitor_loop();
            ready_loop();
            frame_loop();
        join_none
        @(posedge clk);
        #1;

        do_reset();

        // Latency: exactly one valid pulse, at the tenth edge after the pin change.
        rdy_fixed = 1'b1;
        apply(4'b1110, 7'h12, 20, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            check("latency_valid", 32'(out_valid), 32'(k == 10));
            if (k == 10) begin
                check("latency_digit", 32'(out_digit), 32'd2);
                check("latency_index", 32'(out_index), 32'd0);
                check("latency_err", 32'(out_err), 32'd0);
            end
        end

        // Glitch shorter than the settle window is ignored.
        apply_hold(4'b1110, 7'h06, 5, 1'b1);
        apply_hold(4'b1110, 7'h4C, 12, 1'b1);
        apply_hold(4'b1111, 7'h7F, 4, 1'b1);
        check("glitch_drained", 32'(exp_q.size()), 32'd0);

        // Undecodable pattern, then a multi-hot select.
        apply_hold(4'b1011, 7'h55, 12, 1'b1);
        apply_hold(4'b1100, 7'h01, 12, 1'b1);
        apply_hold(4'b1111, 7'h7F, 4, 1'b1);
        check("badpat_drained", 32'(exp_q.size()), 32'd0);

        // Randomised scan with random backpressure.
        rdy_mode = 1'b1;
        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) rd = ~(ND'(1) << $urandom_range(0, ND - 1));
            else if (r == 7) rd = '1;
            else if (r == 8) rd = ~(ND'(3) << $urandom_range(0, ND - 2));
            else rd = '0;
            r = $urandom_range(0, 15);
            if (r < 12) rs = tbl[$urandom_range(0, 15)];
            else if (r < 14) rs = 7'h7F;
            else rs = 7'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                rd = m_dig;
                rs = m_seg;
            end
            apply_hold(rd, rs, $urandom_range(1, 14), 1'b1);
        end
        apply_hold(4'b1111, 7'h7F, 20, 1'b1);
        rdy_mode = 1'b0;
        check("random_drained", 32'(exp_q.size()), 32'd0);
        check("random_no_overflow", 32'(overflow), 32'd0);

        // Frame assembly.
        do_reset();
        rdy_fixed = 1'b1;
`ifdef SEVSEG_FRAME_EN
        fv_cnt = 0;
`endif
        apply_hold(4'b1110, 7'h4F, 10, 1'b1);
        apply_hold(4'b1101, 7'h12, 10, 1'b1);
        apply_hold(4'b1011, 7'h06, 10, 1'b1);
        apply_hold(4'b0111, 7'h4C, 10, 1'b1);
        apply_hold(4'b1111, 7'h7F, 5, 1'b1);
`ifdef SEVSEG_FRAME_EN
        check("frame_pulses", 32'(fv_cnt), 32'd1);
        check("frame_value", 32'(fv_frame), 32'h4321);
`else
        check("frame_pulses", 32'(fv_cnt), 32'd0);
        check("frame_nonzero_cycles", 32'(nz_frame), 32'd0);
`endif
        check("frame_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: second capture dropped, first held, overflow sticky.
        rdy_fixed = 1'b0;
        apply_hold(4'b1101, 7'h0F, 12, 1'b1);
        apply_hold(4'b1011, 7'h01, 12, 1'b0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_digit", 32'(out_digit), 32'd7);
        check("bp_index", 32'(out_index), 32'd1);
        check("bp_overflow", 32'(overflow), 32'd1);
        rdy_fixed = 1'b1;
        cyc(1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_overflow_sticky", 32'(overflow), 32'd1);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset while a capture is waiting.
        rdy_fixed = 1'b0;
        apply_hold(4'b1110, 7'h4F, 12, 1'b1);
        check("midrst_pending", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        apply(4'b1111, 7'h7F, 0, 1'b0);
        cyc(1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_digit", 32'(out_digit), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
